traffic_intersection: RTL and testbench



---
 rtl/traffic_intersection.sv | 124 ++++++++++++
 tb/tb_traffic_intersection.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection.sv
// rtl/traffic_intersection.sv - two-road intersection controller with pedestrian walk and EW sensor hold
// Moore FSM plus a per-phase up-counter that clears on every state change and saturates at the phase's last count.
module traffic_intersection #(
  parameter int CNT_W          = 8,
  parameter int GREEN_CYCLES   = 4,
  parameter int YELLOW_CYCLES  = 2,
  parameter int ALL_RED_CYCLES = 1,
  parameter int WALK_CYCLES    = 3,
  parameter int MIN_GREEN      = 2,
  parameter int EW_SENSE_EN    = 0
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       ped_req,
  input  logic       ew_car,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    WALK_A    = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    RED_B     = 3'd6,
    WALK_B    = 3'd7
  } state_t;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LAST  = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MIN_GREEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_pending_q, ped_pending_d;

  logic [CNT_W-1:0] last_cnt;
  logic             at_end;
  logic             in_walk;
  logic             early_exit;
  logic             ns_hold;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q       <= NS_GREEN;
      cnt_q         <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ped_pending_d = ped_pending_q;
    last_cnt      = G_LAST;
    at_end        = 1'b0;
    in_walk       = (state_q == WALK_A) || (state_q == WALK_B);
    early_exit    = ped_pending_q && (cnt_q >= MG_LAST);
    ns_hold       = (EW_SENSE_EN != 0) && !ew_car && !ped_pending_q;

    case (state_q)
      NS_YELLOW, EW_YELLOW: last_cnt = Y_LAST;
      RED_A, RED_B:         last_cnt = R_LAST;
      WALK_A, WALK_B:       last_cnt = W_LAST;
      default:              last_cnt = G_LAST;
    endcase
    at_end = (cnt_q == last_cnt);

    case (state_q)
      NS_GREEN:  if (early_exit || (at_end && !ns_hold)) state_d = NS_YELLOW;
      NS_YELLOW: if (at_end) state_d = RED_A;
      RED_A:     if (at_end) state_d = ped_pending_q ? WALK_A : EW_GREEN;
      WALK_A:    if (at_end) state_d = EW_GREEN;
      EW_GREEN:  if (early_exit || at_end) state_d = EW_YELLOW;
      EW_YELLOW: if (at_end) state_d = RED_B;
      RED_B:     if (at_end) state_d = ped_pending_q ? WALK_B : NS_GREEN;
      WALK_B:    if (at_end) state_d = NS_GREEN;
      default:   state_d = NS_GREEN;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (!at_end) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Entering a walk consumes the request even if the button is still pressed.
    if (!in_walk && ((state_d == WALK_A) || (state_d == WALK_B))) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && !in_walk) begin
      ped_pending_d = 1'b1;
    end
  end

  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    walk     = 1'b0;
    phase    = state_q;
    case (state_q)
      NS_GREEN:       ns_light = LIGHT_GREEN;
      NS_YELLOW:      ns_light = LIGHT_YELLOW;
      EW_GREEN:       ew_light = LIGHT_GREEN;
      EW_YELLOW:      ew_light = LIGHT_YELLOW;
      WALK_A, WALK_B: walk     = 1'b1;
      default:        ;
    endcase
  end

endmodule

// File: tb/tb_traffic_intersection.sv
// tb/tb_traffic_intersection.sv - directed self-checking bench for traffic_intersection
// Three instances: default timing, EW sensor hold enabled, and all-ones durations.
module tb_traffic_intersection;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d = 1'b0, ped_d = 1'b0, car_d = 1'b0;
  logic [1:0] ns_d, ew_d;
  logic       walk_d;
  logic [2:0] ph_d;

  logic       rst_s = 1'b0, ped_s = 1'b0, car_s = 1'b0;
  logic [1:0] ns_s, ew_s;
  logic       walk_s;
  logic [2:0] ph_s;

  logic       rst_f = 1'b0, ped_f = 1'b0, car_f = 1'b0;
  logic [1:0] ns_f, ew_f;
  logic       walk_f;
  logic [2:0] ph_f;

  int pass_cnt = 0;
  int total_cnt = 0;

  traffic_intersection u_def (
    .clk(clk), .rstb(rst_d), .ped_req(ped_d), .ew_car(car_d),
    .ns_light(ns_d), .ew_light(ew_d), .walk(walk_d), .phase(ph_d)
  );

  traffic_intersection #(.EW_SENSE_EN(1)) u_sense (
    .clk(clk), .rstb(rst_s), .ped_req(ped_s), .ew_car(car_s),
    .ns_light(ns_s), .ew_light(ew_s), .walk(walk_s), .phase(ph_s)
  );

  traffic_intersection #(
    .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALL_RED_CYCLES(1),
    .WALK_CYCLES(1), .MIN_GREEN(1), .EW_SENSE_EN(0)
  ) u_fast (
    .clk(clk), .rstb(rst_f), .ped_req(ped_f), .ew_car(car_f),
    .ns_light(ns_f), .ew_light(ew_f), .walk(walk_f), .phase(ph_f)
  );

  function automatic logic [2:0] rot_phase(input int i);
    int m;
    m = i % 14;
    if (m < 4) return 3'd0;
    if (m < 6) return 3'd1;
    if (m < 7) return 3'd2;
    if (m < 11) return 3'd4;
    if (m < 13) return 3'd5;
    return 3'd6;
  endfunction

  function automatic logic [3:0] exp_lights(input logic [2:0] p);
    case (p)
      3'd0:    return 4'b01_00;
      3'd1:    return 4'b10_00;
      3'd4:    return 4'b00_01;
      3'd5:    return 4'b00_10;
      default: return 4'b00_00;
    endcase
  endfunction

  task automatic test_reset();
    #1;
    rst_d = 1'b1;
    rst_s = 1'b1;
    rst_f = 1'b1;
    #1;
    total_cnt++;
    if ({ph_d, ns_d, ew_d, walk_d} !== {3'd0, 2'b01, 2'b00, 1'b0})
      $display("FAIL reset_outputs: got ph=%0d ns=%b ew=%b walk=%b expected ph=0 ns=01 ew=00 walk=0", ph_d, ns_d, ew_d, walk_d);
    else pass_cnt++;
    total_cnt++;
    if (u_def.ped_pending_q !== 1'b0)
      $display("FAIL reset_pending: got %b expected 0", u_def.ped_pending_q);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_d = 1'b0;
  endtask

  task automatic test_rotation();
    for (int i = 0; i < 28; i++) begin
      total_cnt++;
      if (ph_d !== rot_phase(i))
        $display("FAIL rotation_phase[%0d]: got %0d expected %0d", i, ph_d, rot_phase(i));
      else pass_cnt++;
      total_cnt++;
      if ({ns_d, ew_d, walk_d} !== {exp_lights(rot_phase(i)), 1'b0})
        $display("FAIL rotation_lights[%0d]: got ns=%b ew=%b walk=%b expected %b walk=0", i, ns_d, ew_d, walk_d, exp_lights(rot_phase(i)));
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_ped_pulse();
    logic [2:0] exp_ph [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    for (int k = 0; k < 9; k++) begin
      total_cnt++;
      if (ph_d !== exp_ph[k] || walk_d !== (exp_ph[k] == 3'd3))
        $display("FAIL ped_pulse[%0d]: got ph=%0d walk=%b expected ph=%0d", k, ph_d, walk_d, exp_ph[k]);
      else pass_cnt++;
      if (k == 5) begin
        total_cnt++;
        if (u_def.ped_pending_q !== 1'b0)
          $display("FAIL ped_pulse_cleared: got %b expected 0", u_def.ped_pending_q);
        else pass_cnt++;
      end
      if (k < 8) begin
        ped_d = (k == 0);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_ped_held();
    logic [2:0] exp_ph [11] = '{3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};
    int walks;
    walks = 0;
    ped_d = 1'b1;
    for (int j = 0; j < 11; j++) begin
      total_cnt++;
      if (ph_d !== exp_ph[j])
        $display("FAIL ped_held[%0d]: got ph=%0d expected %0d", j, ph_d, exp_ph[j]);
      else pass_cnt++;
      if (walk_d === 1'b1) walks++;
      if (j == 9) begin
        total_cnt++;
        if (u_def.ped_pending_q !== 1'b1)
          $display("FAIL ped_held_reset_pending: got %b expected 1", u_def.ped_pending_q);
        else pass_cnt++;
        ped_d = 1'b0;
      end
      if (j < 10) @(negedge clk);
    end
    total_cnt++;
    if (walks != 3)
      $display("FAIL ped_held_walk_once: got %0d walk cycles expected 3", walks);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (ph_d == 3'd5) found = 1'b1;
    end
    total_cnt++;
    if (!found)
      $display("FAIL async_reset_wait: EW_YELLOW not reached within 40 cycles, got ph=%0d expected 5", ph_d);
    else pass_cnt++;
    ped_d = 1'b1;
    @(posedge clk);
    #1;
    ped_d = 1'b0;
    total_cnt++;
    if (ph_d !== 3'd5 || u_def.ped_pending_q !== 1'b1)
      $display("FAIL async_reset_setup: got ph=%0d pending=%b expected ph=5 pending=1", ph_d, u_def.ped_pending_q);
    else pass_cnt++;
    #1;
    rst_d = 1'b1;
    #1;
    total_cnt++;
    if ({ph_d, ns_d, ew_d, walk_d} !== {3'd0, 2'b01, 2'b00, 1'b0})
      $display("FAIL async_reset_outputs: got ph=%0d ns=%b ew=%b walk=%b expected ph=0 ns=01 ew=00 walk=0", ph_d, ns_d, ew_d, walk_d);
    else pass_cnt++;
    total_cnt++;
    if (u_def.ped_pending_q !== 1'b0)
      $display("FAIL async_reset_pending: got %b expected 0", u_def.ped_pending_q);
    else pass_cnt++;
    @(negedge clk);
    rst_d = 1'b0;
    for (int i = 0; i < 9; i++) begin
      total_cnt++;
      if (ph_d !== rot_phase(i))
        $display("FAIL async_reset_after[%0d]: got ph=%0d expected %0d", i, ph_d, rot_phase(i));
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_ew_sense();
    logic [2:0] exp_ph [4] = '{3'd1, 3'd1, 3'd2, 3'd4};
    @(negedge clk);
    rst_s = 1'b0;
    car_s = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total_cnt++;
      if (ph_s !== 3'd0 || ns_s !== 2'b01)
        $display("FAIL ew_sense_hold[%0d]: got ph=%0d ns=%b expected ph=0 ns=01", i, ph_s, ns_s);
      else pass_cnt++;
      @(negedge clk);
    end
    car_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (ph_s !== exp_ph[i])
        $display("FAIL ew_sense_release[%0d]: got ph=%0d expected %0d", i, ph_s, exp_ph[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fast_sweep();
    logic [2:0] exp_ph [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd0};
    logic [2:0] prev;
    int viol, repeats, walks;
    viol = 0;
    repeats = 0;
    walks = 0;
    @(negedge clk);
    rst_f = 1'b0;
    for (int i = 0; i < 7; i++) begin
      total_cnt++;
      if (ph_f !== exp_ph[i])
        $display("FAIL fast_sequence[%0d]: got ph=%0d expected %0d", i, ph_f, exp_ph[i]);
      else pass_cnt++;
      prev = ph_f;
      @(negedge clk);
    end
    for (int i = 0; i < 1000; i++) begin
      if ((ns_f != 2'b00 && ew_f != 2'b00) || (walk_f && (ns_f != 2'b00 || ew_f != 2'b00)) ||
          ns_f == 2'b11 || ew_f == 2'b11)
        viol++;
      if (ph_f == prev) repeats++;
      if (walk_f) walks++;
      prev = ph_f;
      ped_f = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ped_f = 1'b0;
    total_cnt++;
    if (viol != 0)
      $display("FAIL fast_safety: got %0d violations expected 0", viol);
    else pass_cnt++;
    total_cnt++;
    if (repeats != 0)
      $display("FAIL fast_one_cycle_states: got %0d repeated phases expected 0", repeats);
    else pass_cnt++;
    total_cnt++;
    if (walks == 0)
      $display("FAIL fast_walk_served: got %0d walk cycles expected >0", walks);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_ped_pulse();
    test_ped_held();
    test_async_reset();
    test_ew_sense();
    test_fast_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
